// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, default widths and counter sizing for mem_unit
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RBUSY = 2'd1,
        WBUSY = 2'd2
    } state_e;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_WAIT_STATES = 1;

    // Wait counter must hold WAIT_STATES; never narrower than one bit.
    function automatic int cnt_width(input int wait_states);
        return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
    endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - storage array with synchronous write and combinational read
module mem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // No reset: contents survive AR.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_unit.sv
// rtl/mem_unit.sv - bus-side memory responder with MAR/MDR, wait states and tri-state bus drive
module mem_unit
    import mem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic              CLK,
    input  logic              AR,
    input  logic              MLA,
    input  logic              MAI,
    input  logic              MOA,
    input  logic              MRD,
    input  logic              MWR,
    input  logic              MOD,
    output logic              RDY,
    inout  wire  [DATA_W-1:0] DATA,
    inout  wire  [ADDR_W-1:0] ADDR
);

    localparam int              CNT_W    = cnt_width(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [ADDR_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] wdr_q, wdr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] acc_sel;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .waddr_i (acc_q),
        .wdata_i (wdr_q),
        .raddr_i (acc_q),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge CLK or posedge AR) begin
        if (AR) begin
            state_q <= IDLE;
            mar_q   <= '0;
            acc_q   <= '0;
            mdr_q   <= '0;
            wdr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            acc_q   <= acc_d;
            mdr_q   <= mdr_d;
            wdr_q   <= wdr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        acc_d   = acc_q;
        mdr_d   = mdr_q;
        wdr_d   = wdr_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        RDY     = 1'b0;
        // A combined MLA+MRD/MWR accesses the address being loaded, not the old MAR.
        acc_sel = MLA ? ADDR : mar_q;
        unique case (state_q)
            IDLE: begin
                RDY = 1'b1;
                if (MLA) begin
                    mar_d = ADDR;
                end else if (MAI) begin
                    mar_d = mar_q + 1'b1;
                end
                if (MWR) begin
                    wdr_d   = DATA;
                    acc_d   = acc_sel;
                    cnt_d   = CNT_LOAD;
                    state_d = WBUSY;
                end else if (MRD) begin
                    acc_d   = acc_sel;
                    cnt_d   = CNT_LOAD;
                    state_d = RBUSY;
                end
            end
            RBUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    mdr_d   = mem_rdata;
                    state_d = IDLE;
                end
            end
            WBUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign DATA = (MOD && !AR) ? mdr_q : {DATA_W{1'bz}};
    assign ADDR = (MOA && !AR) ? mar_q : {ADDR_W{1'bz}};

endmodule
